// File: rtl/candidate_sink.sv
// Candidate sink: accepts corrected-read candidates from the output queue and serialises each
// read group as {meta, input read, candidates...} beats. Optional stats via CANDIDATE_SINK_STATS_EN.
module candidate_sink #(
  parameter int MAX_READ_BIT_WIDTH       = 8,
  parameter int MAX_READ_WIDTH           = 256,
  parameter int NUM_CANDIDATES_BIT_WIDTH = 5,
  parameter int OUT_WIDTH                = 64
) (
  input  logic                                clk,
  input  logic                                rstb,
  input  logic [2*MAX_READ_WIDTH-1:0]         candidate,
  input  logic                                candidateValid,
  input  logic [NUM_CANDIDATES_BIT_WIDTH:0]   candidateNum,
  input  logic                                candidateNumValid,
  input  logic [2*MAX_READ_WIDTH-1:0]         inputRead,
  output logic                                ready4Candidate,
  output logic [OUT_WIDTH-1:0]                outData,
  output logic                                outValid,
  input  logic                                outReady,
  output logic                                outFirst,
  output logic                                outLast,
  output logic                                protocolError,
  output logic [1:0]                          state_dbg
`ifdef CANDIDATE_SINK_STATS_EN
  ,
  output logic [31:0]                         statGroups,
  output logic [31:0]                         statCandidates
`endif
);

  localparam int RW    = 2 * MAX_READ_WIDTH;
  localparam int NW    = NUM_CANDIDATES_BIT_WIDTH + 1;
  localparam int BEATS = RW / OUT_WIDTH;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((RW % OUT_WIDTH) != 0 || OUT_WIDTH < NW || MAX_READ_WIDTH > (1 << MAX_READ_BIT_WIDTH))
  begin : g_bad_params
    $error("candidate_sink: illegal parameter combination");
  end

  // Handshakes: input candidate is taken when ready4Candidate & candidateValid & candidateNumValid;
  // an output beat moves when outValid & outReady, and outData/outFirst/outLast hold while stalled.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_META = 2'd1,
    S_READ = 2'd2,
    S_CAND = 2'd3
  } state_t;

  state_t                           state, state_next;
  logic                             hold_full;
  logic [BEATS-1:0][OUT_WIDTH-1:0]  read_q, cand_q;
  logic [NW-1:0]                    num_q, cand_cnt;
  logic                             first_of_group;
  logic [BW-1:0]                    beat_idx;
  logic                             prot_err;

  logic acc, num_zero, mismatch, start_grp, take, xfer, beat_last, grp_last, cand_done;

  assign ready4Candidate = ~hold_full;
  assign acc       = ready4Candidate & candidateValid & candidateNumValid;
  assign num_zero  = (candidateNum == '0);
  assign mismatch  = ~first_of_group & (candidateNum != num_q);
  assign start_grp = first_of_group | mismatch;
  assign take      = acc & ~num_zero;
  assign xfer      = outValid & outReady;
  assign beat_last = (beat_idx == BW'(BEATS - 1));
  assign grp_last  = (cand_cnt == num_q - NW'(1));
  assign cand_done = xfer & (state == S_CAND) & beat_last;

  assign protocolError = prot_err;
  assign state_dbg     = state;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_next;
  end

  // Leaving IDLE on the accept edge itself puts the first beat on the bus one cycle later.
  always_comb begin
    state_next = state;
    outValid   = 1'b0;
    outFirst   = 1'b0;
    outLast    = 1'b0;
    outData    = '0;
    case (state)
      S_IDLE: begin
        if (take)           state_next = start_grp ? S_META : S_CAND;
        else if (hold_full) state_next = first_of_group ? S_META : S_CAND;
      end
      S_META: begin
        outValid = 1'b1;
        outFirst = 1'b1;
        outData  = OUT_WIDTH'(num_q);
        if (xfer) state_next = S_READ;
      end
      S_READ: begin
        outValid = 1'b1;
        outData  = read_q[beat_idx];
        if (xfer && beat_last) state_next = S_CAND;
      end
      S_CAND: begin
        outValid = 1'b1;
        outData  = cand_q[beat_idx];
        outLast  = beat_last & grp_last;
        if (xfer && beat_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hold_full      <= 1'b0;
      read_q         <= '0;
      cand_q         <= '0;
      num_q          <= '0;
      cand_cnt       <= '0;
      first_of_group <= 1'b1;
      beat_idx       <= '0;
      prot_err       <= 1'b0;
    end else begin
      if (take) begin
        hold_full <= 1'b1;
        read_q    <= inputRead;
        cand_q    <= candidate;
        num_q     <= candidateNum;
        // A count change mid-group abandons the old group and restarts with a fresh meta beat.
        if (mismatch) begin
          cand_cnt       <= '0;
          first_of_group <= 1'b1;
        end
      end
      if (acc && (num_zero || mismatch)) prot_err <= 1'b1;
      if (xfer) begin
        if (state == S_META || beat_last) beat_idx <= '0;
        else                              beat_idx <= beat_idx + BW'(1);
      end
      if (cand_done) begin
        hold_full <= 1'b0;
        if (grp_last) begin
          cand_cnt       <= '0;
          first_of_group <= 1'b1;
        end else begin
          cand_cnt       <= cand_cnt + NW'(1);
          first_of_group <= 1'b0;
        end
      end
    end
  end

`ifdef CANDIDATE_SINK_STATS_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      statGroups     <= '0;
      statCandidates <= '0;
    end else begin
      if (xfer && outLast) statGroups     <= statGroups + 32'd1;
      if (cand_done)       statCandidates <= statCandidates + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_candidate_sink.sv
// Bench for candidate_sink: drives candidate groups, predicts the beat stream from the record
// format rules and compares every transferred beat, stall stability, ready gaps and error flag.
`timescale 1ns/1ps
module tb_candidate_sink;
  localparam int RW    = 512;
  localparam int OW    = 64;
  localparam int BEATS = 8;
  localparam int NW    = 6;

  logic            clk = 1'b0;
  logic            rstb = 1'b0;
  logic [RW-1:0]   candidate = '0;
  logic            candidateValid = 1'b0;
  logic [NW-1:0]   candidateNum = '0;
  logic            candidateNumValid = 1'b0;
  logic [RW-1:0]   inputRead = '0;
  logic            ready4Candidate;
  logic [OW-1:0]   outData;
  logic            outValid;
  logic            outReady = 1'b1;
  logic            outFirst;
  logic            outLast;
  logic            protocolError;
  logic [1:0]      state_dbg;
`ifdef CANDIDATE_SINK_STATS_EN
  logic [31:0]     statGroups;
  logic [31:0]     statCandidates;
`endif

  candidate_sink dut (
    .clk               (clk),
    .rstb              (rstb),
    .candidate         (candidate),
    .candidateValid    (candidateValid),
    .candidateNum      (candidateNum),
    .candidateNumValid (candidateNumValid),
    .inputRead         (inputRead),
    .ready4Candidate   (ready4Candidate),
    .outData           (outData),
    .outValid          (outValid),
    .outReady          (outReady),
    .outFirst          (outFirst),
    .outLast           (outLast),
    .protocolError     (protocolError),
    .state_dbg         (state_dbg)
`ifdef CANDIDATE_SINK_STATS_EN
    ,
    .statGroups        (statGroups),
    .statCandidates    (statCandidates)
`endif
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: each entry is {last, first, data}
  logic [OW+1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int mon_beats = 0;
  int rdy_mode = 0;

  // reference model of group bookkeeping
  bit m_first = 1'b1;
  int m_cnt = 0;
  int m_num = 0;
  bit m_err = 1'b0;
  int m_groups = 0;
  int m_cands = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rand_vec();
    logic [RW-1:0] v;
    for (int i = 0; i < RW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_accept(input int num, input logic [RW-1:0] rd, input logic [RW-1:0] cd);
    bit last;
    if (num == 0) begin
      m_err = 1'b1;
      return;
    end
    if (!m_first && num != m_num) begin
      m_err = 1'b1;
      m_first = 1'b1;
      m_cnt = 0;
    end
    m_num = num;
    if (m_first) begin
      exp_q.push_back({1'b0, 1'b1, OW'(num)});
      for (int i = 0; i < BEATS; i++) exp_q.push_back({2'b00, rd[i*OW +: OW]});
    end
    m_cnt++;
    last = (m_cnt == num);
    for (int i = 0; i < BEATS; i++)
      exp_q.push_back({(last && i == BEATS - 1) ? 1'b1 : 1'b0, 1'b0, cd[i*OW +: OW]});
    m_cands++;
    if (last) begin
      m_groups++;
      m_first = 1'b1;
      m_cnt = 0;
    end else begin
      m_first = 1'b0;
    end
  endtask

  // monitor: compare every transferred beat and check stability across stalls
  bit            stalled = 1'b0;
  logic [OW+1:0] held;
  logic [OW+1:0] got_w;
  always @(negedge clk) begin
    if (!rstb) begin
      stalled = 1'b0;
    end else begin
      got_w = {outLast, outFirst, outData};
      if (stalled) check_eq("stall_hold", {outValid, got_w}, {1'b1, held});
      if (outValid) begin
        if (exp_q.size() == 0) check_eq("spurious_beat", outValid, 1'b0);
        else if (outReady) begin
          check_eq("beat", got_w, exp_q.pop_front());
          mon_beats++;
        end
      end
      stalled = outValid & ~outReady;
      held = got_w;
    end
  end

  // downstream ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       outReady = 1'b1;
        1:       outReady = ~outReady;
        default: outReady = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // driver tasks
  task automatic send(input int num, input logic [RW-1:0] rd, input logic [RW-1:0] cd,
                      input bit measure, output int lo);
    bit got_it;
    got_it = 1'b0;
    lo = 0;
    @(posedge clk);
    #1;
    candidate = cd;
    inputRead = rd;
    candidateNum = NW'(num);
    candidateValid = 1'b1;
    candidateNumValid = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (ready4Candidate) begin
        model_accept(num, rd, cd);
        got_it = 1'b1;
        break;
      end
    end
    if (!got_it) check_eq("accept_timeout", ready4Candidate, 1'b1);
    @(posedge clk);
    #1;
    candidateValid = 1'b0;
    candidateNumValid = 1'b0;
    candidate = rand_vec();
    inputRead = rand_vec();
    candidateNum = NW'($urandom_range(0, 63));
    if (measure && got_it) begin
      for (int k = 0; k < 600; k++) begin
        @(negedge clk);
        if (ready4Candidate) break;
        lo++;
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || outValid) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2 rstb = 1'b0;
    #1;
    check_eq("rst_ready", ready4Candidate, 1'b1);
    check_eq("rst_valid", outValid, 1'b0);
    check_eq("rst_first", outFirst, 1'b0);
    check_eq("rst_last", outLast, 1'b0);
    check_eq("rst_data", outData, '0);
    check_eq("rst_err", protocolError, 1'b0);
    exp_q.delete();
    m_first = 1'b1;
    m_cnt = 0;
    m_num = 0;
    m_err = 1'b0;
    m_groups = 0;
    m_cands = 0;
    repeat (2) @(posedge clk);
    #1 rstb = 1'b1;
  endtask

  // test sequence
  initial begin
    int lo;
    int base;
    int num;
    apply_reset();

    // single-candidate group
    send(1, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t1_ready_low", lo, 17);
    drain();
    check_eq("t1_err", protocolError, 1'b0);

    // three candidates, one meta beat
    send(3, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t2_ready_low0", lo, 17);
    send(3, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t2_ready_low1", lo, BEATS);
    send(3, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t2_ready_low2", lo, BEATS);
    drain();

    // toggling outReady
    rdy_mode = 1;
    for (int c = 0; c < 2; c++) begin
      send(2, rand_vec(), rand_vec(), 1'b1, lo);
      check_eq("t3_gap", lo >= BEATS, 1'b1);
    end
    drain();
    rdy_mode = 0;
    check_eq("t3_err", protocolError, 1'b0);

    // zero-count candidate is dropped
    send(0, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t4_ready_stays", lo, 0);
    check_eq("t4_err", protocolError, 1'b1);
    send(1, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t4_ready_low", lo, 17);
    drain();
    check_eq("t4_err_sticky", protocolError, m_err);

    // group of 4 interrupted by a group of 2
    apply_reset();
    send(4, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t5_low0", lo, 17);
    send(4, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t5_low1", lo, BEATS);
    send(2, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t5_low2", lo, 17);
    send(2, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t5_low3", lo, BEATS);
    drain();
    check_eq("t5_err", protocolError, m_err);

    // reset in the middle of the read section
    base = mon_beats;
    send(1, rand_vec(), rand_vec(), 1'b0, lo);
    for (int k = 0; k < 100; k++) begin
      if (mon_beats >= base + 4) break;
      @(negedge clk);
    end
    check_eq("t6_mid_record", outValid, 1'b1);
    apply_reset();
    send(1, rand_vec(), rand_vec(), 1'b1, lo);
    check_eq("t6_ready_low", lo, 17);
    drain();

    // largest legal group
    for (int c = 0; c < 32; c++) send(32, rand_vec(), rand_vec(), 1'b0, lo);
    drain();
    check_eq("t7_err", protocolError, 1'b0);

    // random groups with random backpressure
    rdy_mode = 2;
    for (int g = 0; g < 6; g++) begin
      num = $urandom_range(1, 5);
      for (int c = 0; c < num; c++) begin
        send(num, rand_vec(), rand_vec(), 1'b1, lo);
        check_eq("t8_gap", lo >= BEATS, 1'b1);
      end
    end
    drain();
    rdy_mode = 0;
    check_eq("t8_err", protocolError, 1'b0);

`ifdef CANDIDATE_SINK_STATS_EN
    check_eq("stat_groups", statGroups, m_groups);
    check_eq("stat_candidates", statCandidates, m_cands);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
